// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared pipeline types and fixed stage indices
package cpu_types_pkg;
    typedef enum logic [1:0] {RUN, LUSTALL, DWAIT, HALTED} hzstate_t;
    localparam int IF_STG = 0;
    localparam int ID_STG = 1;
    localparam int EX_STG = 2;
endpackage

// File: rtl/hazard_loaduse_det.sv
// hazard_loaduse_det: flags an ID-stage source that needs the result of a load still in EX
module hazard_loaduse_det (
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    output logic       lu_hazard_o
);
    assign lu_hazard_o = ex_memread_i & (ex_rd_i != 5'd0) &
                         ((ex_rd_i == id_rs_i) | (id_uses_rt_i & (ex_rd_i == id_rt_i)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller driving every pipeline latch enable and the PC enable
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int MEM_STAGE  = 3,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  nrst_i,
    input  logic                  ihit_i,
    input  logic                  dhit_i,
    input  logic                  mem_ren_i,
    input  logic                  mem_wen_i,
    input  logic                  ex_memread_i,
    input  logic [4:0]            ex_rd_i,
    input  logic [4:0]            id_rs_i,
    input  logic [4:0]            id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  branch_taken_i,
    input  logic                  halt_i,
    output logic [NUM_STAGES-2:0] latch_wen_o,
    output logic [NUM_STAGES-2:0] latch_flush_o,
    output logic                  pc_wen_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);
    hzstate_t         state_q, state_d;
    logic [1:0]       lu_cnt_q, lu_cnt_d;
    logic             squash_pend_q, squash_pend_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             lu_hazard, lu_pend, halted, dwait, br, lu, stall_inc;

    hazard_loaduse_det u_lu_det (
        .ex_memread_i (ex_memread_i),
        .ex_rd_i      (ex_rd_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_uses_rt_i (id_uses_rt_i),
        .lu_hazard_o  (lu_hazard)
    );

    // remaining bubbles survive a dcache wait, so a pending count stands in for LUSTALL
    assign lu_pend = lu_cnt_q != 2'd0;
    assign stall_inc = !pc_wen_o & (state_q != HALTED) & ~&stall_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

    // state, bubble count, squash flag and saturating stall counter
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q       <= RUN;
            lu_cnt_q      <= 2'd0;
            squash_pend_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            lu_cnt_q      <= lu_cnt_d;
            squash_pend_q <= squash_pend_d;
            stall_cnt_q   <= stall_cnt_q + CNT_W'(stall_inc);
        end
    end

    // next state in priority order: halt, dcache wait, branch, load-use, fetch
    always_comb begin
        state_d       = state_q;
        lu_cnt_d      = lu_cnt_q;
        squash_pend_d = squash_pend_q;
        if (halted) begin
            state_d = HALTED;
        end else if (dwait) begin
            state_d = DWAIT;
        end else if (br) begin
            state_d       = RUN;
            lu_cnt_d      = 2'd0;
            squash_pend_d = squash_pend_q | !ihit_i;
        end else if (lu) begin
            lu_cnt_d = lu_pend ? lu_cnt_q - 2'd1 : 2'(LU_BUBBLES - 1);
            state_d  = (lu_cnt_d != 2'd0) ? LUSTALL : RUN;
        end else begin
            state_d       = RUN;
            squash_pend_d = squash_pend_q & !ihit_i;
        end
    end

    // winning condition this cycle and the PC enable
    always_comb begin
        halted   = halt_i | (state_q == HALTED);
        dwait    = (mem_ren_i | mem_wen_i) & !dhit_i;
        br       = branch_taken_i & !dwait;
        lu       = (lu_hazard | lu_pend) & !br & !dwait;
        pc_wen_o = nrst_i & !halted & !dwait & (br | (!lu & ihit_i & !squash_pend_q));
    end

    for (genvar i = 0; i < NUM_STAGES - 1; i++) begin : g_latch
        assign latch_wen_o[i] = !nrst_i | (!halted & (dwait ? (i >= MEM_STAGE) : !(lu & (i == IF_STG))));
        assign latch_flush_o[i] = !nrst_i | (!halted & (dwait ? (i == MEM_STAGE) :
                                  br ? (i <= ID_STG) : lu ? (i == ID_STG) :
                                  ((i == IF_STG) & (!ihit_i | squash_pend_q))));
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table-driven scoreboard bench for the stall/flush controller
module tb_pipeline_hazard_ctrl;
    logic        clk = 1'b0;
    logic        nrst, ihit, dhit, ren, wen, exmr, urt, br, halt;
    logic [4:0]  exrd, rs, rt;
    logic [3:0]  latch_wen, latch_flush;
    logic        pc_wen;
    logic [31:0] stall_cnt;

    typedef struct {
        logic        nrst, ihit, dhit, ren, wen, exmr;
        logic [4:0]  exrd, rs, rt;
        logic        urt, br, halt;
        logic [3:0]  ewen, efl;
        logic        epc;
        logic [31:0] ecnt;
        int          id;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   nvec = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.NUM_STAGES(5), .MEM_STAGE(3), .LU_BUBBLES(2), .CNT_W(32)) dut (
        .clk_i          (clk),
        .nrst_i         (nrst),
        .ihit_i         (ihit),
        .dhit_i         (dhit),
        .mem_ren_i      (ren),
        .mem_wen_i      (wen),
        .ex_memread_i   (exmr),
        .ex_rd_i        (exrd),
        .id_rs_i        (rs),
        .id_rt_i        (rt),
        .id_uses_rt_i   (urt),
        .branch_taken_i (br),
        .halt_i         (halt),
        .latch_wen_o    (latch_wen),
        .latch_flush_o  (latch_flush),
        .pc_wen_o       (pc_wen),
        .stall_cnt_o    (stall_cnt)
    );

    task automatic add(input logic n, ih, dh, rn, wn, mr, input logic [4:0] d, s, t,
                       input logic u, b, h, input logic [3:0] ew, ef, input logic ep, input logic [31:0] ec);
        vec_t v;
        v.nrst = n; v.ihit = ih; v.dhit = dh; v.ren = rn; v.wen = wn; v.exmr = mr;
        v.exrd = d; v.rs = s; v.rt = t; v.urt = u; v.br = b; v.halt = h;
        v.ewen = ew; v.efl = ef; v.epc = ep; v.ecnt = ec; v.id = tbl.size();
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        nrst = v.nrst; ihit = v.ihit; dhit = v.dhit; ren = v.ren; wen = v.wen; exmr = v.exmr;
        exrd = v.exrd; rs = v.rs; rt = v.rt; urt = v.urt; br = v.br; halt = v.halt;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            vec_t e;
            e = exp_q.pop_front();
            checks += 4;
            if (latch_wen !== e.ewen) begin
                errors++;
                $display("FAIL v%0d latch_wen got %b want %b", e.id, latch_wen, e.ewen);
            end
            if (latch_flush !== e.efl) begin
                errors++;
                $display("FAIL v%0d latch_flush got %b want %b", e.id, latch_flush, e.efl);
            end
            if (pc_wen !== e.epc) begin
                errors++;
                $display("FAIL v%0d pc_wen got %b want %b", e.id, pc_wen, e.epc);
            end
            if (stall_cnt !== e.ecnt) begin
                errors++;
                $display("FAIL v%0d stall_cnt got %0d want %0d", e.id, stall_cnt, e.ecnt);
            end
        end
    end

    initial begin
        //  n ih dh rn wn mr exrd rs rt urt br hlt   wen      flush    pc cnt
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'hF, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1, 0);
        add(1, 1, 0, 0, 0, 1, 8, 8, 0, 0, 0, 0, 4'hE, 4'h2, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hE, 4'h2, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1, 2);
        add(1, 1, 0, 0, 0, 1, 8, 3, 8, 0, 0, 0, 4'hF, 4'h0, 1, 2);
        add(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1, 2);
        add(1, 1, 0, 0, 0, 1, 9, 0, 9, 1, 0, 0, 4'hE, 4'h2, 0, 2);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hE, 4'h2, 0, 3);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1, 4);
        add(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'h8, 4'h8, 0, 4);
        add(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'h8, 4'h8, 0, 5);
        add(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'h8, 4'h8, 0, 6);
        add(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 4'h3, 1, 7);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1, 7);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1, 7);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h1, 0, 7);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 4'h3, 1, 8);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h1, 0, 8);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1, 9);
        add(1, 1, 0, 0, 0, 1, 8, 8, 0, 0, 1, 0, 4'hF, 4'h3, 1, 9);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1, 9);
        add(1, 0, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0, 4'hE, 4'h2, 0, 9);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hE, 4'h2, 0, 10);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h1, 0, 11);
        add(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h8, 4'h8, 0, 12);
        add(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 13);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 14);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 14);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'hF, 0, 14);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1, 0);
        add(1, 1, 0, 1, 0, 1, 8, 8, 0, 0, 0, 0, 4'h8, 4'h8, 0, 0);
        add(1, 1, 1, 1, 0, 1, 8, 8, 0, 0, 0, 0, 4'hE, 4'h2, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hE, 4'h2, 0, 2);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1, 3);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 3);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 4);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'hF, 0, 4);
        nrst = 0; ihit = 1; dhit = 0; ren = 0; wen = 0; exmr = 0;
        exrd = 0; rs = 0; rt = 0; urt = 0; br = 0; halt = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);
        nvec = tbl.size();
        for (int k = 0; k < 24; k++) begin
            vec_t v;
            logic haz;
            v.nrst = 1; v.dhit = 0; v.ren = 0; v.wen = 0; v.br = 0; v.halt = 0;
            v.ihit = 1'($urandom_range(0, 1));
            v.exmr = 1'($urandom_range(0, 1));
            v.urt  = 1'($urandom_range(0, 1));
            v.exrd = 5'($urandom_range(0, 3));
            v.rs   = 5'($urandom_range(0, 3));
            v.rt   = 5'($urandom_range(0, 3));
            haz = v.exmr && v.exrd != 0 && (v.exrd == v.rs || (v.urt && v.exrd == v.rt));
            v.ewen = haz ? 4'hE : 4'hF;
            v.efl  = haz ? 4'h2 : (v.ihit ? 4'h0 : 4'h1);
            v.epc  = !haz && v.ihit;
            v.ecnt = 0;
            v.id   = nvec++;
            apply(v);
            v.nrst = 0; v.exmr = 0; v.ihit = 1;
            v.ewen = 4'hF; v.efl = 4'hF;
            v.ecnt = {31'd0, v.epc ? 1'b0 : 1'b1};
            v.epc  = 0;
            v.id   = nvec++;
            apply(v);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
